// File: rtl/ar_srl_fifo_lvl.sv
// SRL-based FIFO with registered output stage, occupancy count,
// programmable almost-full/almost-empty flags and sticky overflow/underflow.
module ar_srl_fifo_lvl #(
  parameter int unsigned width     = 128,
  parameter int unsigned l2depth   = 5,
  parameter int unsigned af_thresh = (2 ** l2depth) - 2,
  parameter int unsigned ae_thresh = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             ENQ,
  input  logic [width-1:0] D_IN,
  input  logic             DEQ,
  output logic             FULL_N,
  output logic             EMPTY_N,
  output logic [width-1:0] D_OUT,
  output logic [l2depth:0] COUNT,
  output logic             AFULL,
  output logic             AEMPTY,
  output logic             OVF,
  output logic             UNF
);

  localparam int unsigned depth = 2 ** l2depth;
  localparam int unsigned cw    = l2depth + 1;

  logic [width-1:0]   srl [depth];
  logic [cw-1:0]      head;
  logic [cw-1:0]      head_nxt;
  logic [cw-1:0]      count_nxt;
  logic [l2depth-1:0] rd_idx;
  logic               srl_empty;
  logic               enq_ok;
  logic               deq_ok;
  logic               move_out;

  // Acceptance, output-register advance and next occupancy
  always_comb begin
    enq_ok    = ENQ & FULL_N;
    deq_ok    = DEQ & EMPTY_N;
    move_out  = !srl_empty && (!EMPTY_N || deq_ok);
    rd_idx    = l2depth'(head - cw'(1));
    head_nxt  = head;
    count_nxt = COUNT;
    if (enq_ok && !move_out)      head_nxt = head + cw'(1);
    else if (!enq_ok && move_out) head_nxt = head - cw'(1);
    if (enq_ok && !deq_ok)        count_nxt = COUNT + cw'(1);
    else if (!enq_ok && deq_ok)   count_nxt = COUNT - cw'(1);
  end

  // Shift-register storage; contents are intentionally never reset
  always_ff @(posedge CLK) begin
    if (enq_ok && !CLR) begin
      for (int i = depth - 1; i > 0; i--) srl[i] <= srl[i-1];
      srl[0] <= D_IN;
    end
  end

  // Control state and registered flags
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head      <= '0;
      srl_empty <= 1'b1;
      COUNT     <= '0;
      FULL_N    <= 1'b1;
      EMPTY_N   <= 1'b0;
      AFULL     <= 1'b0;
      AEMPTY    <= 1'b1;
      D_OUT     <= '0;
      OVF       <= 1'b0;
      UNF       <= 1'b0;
    end else if (CLR) begin
      head      <= '0;
      srl_empty <= 1'b1;
      COUNT     <= '0;
      FULL_N    <= 1'b1;
      EMPTY_N   <= 1'b0;
      AFULL     <= 1'b0;
      AEMPTY    <= 1'b1;
      D_OUT     <= '0;
      OVF       <= 1'b0;
      UNF       <= 1'b0;
    end else begin
      head      <= head_nxt;
      // Goes empty at once, but clears one cycle after the first write lands
      srl_empty <= (head_nxt == '0) || (head == '0);
      COUNT     <= count_nxt;
      FULL_N    <= (count_nxt != cw'(depth));
      AFULL     <= (count_nxt >= cw'(af_thresh));
      AEMPTY    <= (count_nxt <= cw'(ae_thresh));
      if (move_out) begin
        D_OUT   <= srl[rd_idx];
        EMPTY_N <= 1'b1;
      end else if (deq_ok) begin
        EMPTY_N <= 1'b0;
      end
      OVF <= OVF | (ENQ & ~FULL_N);
      UNF <= UNF | (DEQ & ~EMPTY_N);
    end
  end

endmodule

// File: tb/tb_ar_srl_fifo_lvl.sv
// Self-checking bench for ar_srl_fifo_lvl: vector table plus directed
// sequences for fill/drain, streaming, boundaries, CLR and async reset.
module tb_ar_srl_fifo_lvl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CLR;
  logic       ENQ;
  logic       DEQ;
  logic [7:0] D_IN;
  logic       FULL_N;
  logic       EMPTY_N;
  logic [7:0] D_OUT;
  logic [4:0] COUNT;
  logic       AFULL;
  logic       AEMPTY;
  logic       OVF;
  logic       UNF;

  int n_tests = 0;
  int n_fail  = 0;

  // ctl = {enq,deq,clr}; flg = {full_n,empty_n,afull,aempty,ovf,unf}
  typedef struct {
    logic [2:0] ctl;
    logic [7:0] din;
    logic [4:0] count;
    logic [5:0] flg;
    logic       chk_dout;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs [14];

  ar_srl_fifo_lvl #(
    .width    (8),
    .l2depth  (4),
    .af_thresh(14),
    .ae_thresh(1)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .CLR    (CLR),
    .ENQ    (ENQ),
    .D_IN   (D_IN),
    .DEQ    (DEQ),
    .FULL_N (FULL_N),
    .EMPTY_N(EMPTY_N),
    .D_OUT  (D_OUT),
    .COUNT  (COUNT),
    .AFULL  (AFULL),
    .AEMPTY (AEMPTY),
    .OVF    (OVF),
    .UNF    (UNF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [4:0] cnt, input logic [5:0] flg);
    chk({tag, " COUNT"}, 32'(COUNT), 32'(cnt));
    chk({tag, " flags"}, 32'({FULL_N, EMPTY_N, AFULL, AEMPTY, OVF, UNF}), 32'(flg));
  endtask

  task automatic step(input logic e, input logic d, input logic c, input logic [7:0] din);
    @(negedge CLK);
    ENQ  = e;
    DEQ  = d;
    CLR  = c;
    D_IN = din;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{3'b100, 8'hA5, 5'd1, 6'b100100, 1'b0, 8'h00};
    vecs[1]  = '{3'b000, 8'h00, 5'd1, 6'b100100, 1'b0, 8'h00};
    vecs[2]  = '{3'b000, 8'h00, 5'd1, 6'b110100, 1'b1, 8'hA5};
    vecs[3]  = '{3'b010, 8'h00, 5'd0, 6'b100100, 1'b0, 8'h00};
    vecs[4]  = '{3'b010, 8'h00, 5'd0, 6'b100101, 1'b0, 8'h00};
    vecs[5]  = '{3'b001, 8'h00, 5'd0, 6'b100100, 1'b1, 8'h00};
    vecs[6]  = '{3'b110, 8'h11, 5'd1, 6'b100101, 1'b0, 8'h00};
    vecs[7]  = '{3'b001, 8'h00, 5'd0, 6'b100100, 1'b0, 8'h00};
    vecs[8]  = '{3'b100, 8'h22, 5'd1, 6'b100100, 1'b0, 8'h00};
    vecs[9]  = '{3'b100, 8'h33, 5'd2, 6'b100000, 1'b0, 8'h00};
    vecs[10] = '{3'b000, 8'h00, 5'd2, 6'b110000, 1'b1, 8'h22};
    vecs[11] = '{3'b110, 8'h44, 5'd2, 6'b110000, 1'b1, 8'h33};
    vecs[12] = '{3'b010, 8'h00, 5'd1, 6'b110100, 1'b1, 8'h44};
    vecs[13] = '{3'b010, 8'h00, 5'd0, 6'b100100, 1'b1, 8'h44};

    RST = 1'b1; CLR = 1'b0; ENQ = 1'b0; DEQ = 1'b0; D_IN = 8'h00;
    #1;
    chk_state("reset0", 5'd0, 6'b100100);
    chk("reset0 D_OUT", 32'(D_OUT), 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    // Latency, underflow, simultaneous-at-empty and mid-level ENQ&DEQ
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].ctl[2], vecs[i].ctl[1], vecs[i].ctl[0], vecs[i].din);
      chk_state($sformatf("vec%0d", i), vecs[i].count, vecs[i].flg);
      if (vecs[i].chk_dout) chk($sformatf("vec%0d D_OUT", i), 32'(D_OUT), 32'(vecs[i].dout));
    end

    // Fill 0x00..0x0F, overflow attempt, then ordered drain
    step(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'(i));
      chk($sformatf("fill%0d COUNT", i), 32'(COUNT), 32'(i + 1));
      chk($sformatf("fill%0d AFULL", i), 32'(AFULL), 32'((i + 1) >= 14));
      chk($sformatf("fill%0d FULL_N", i), 32'(FULL_N), 32'((i + 1) != 16));
    end
    step(1'b1, 1'b0, 1'b0, 8'hFF);
    chk_state("ovf17", 5'd16, 6'b011010);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d EMPTY_N", i), 32'(EMPTY_N), 32'h1);
      chk($sformatf("drain%0d D_OUT", i), 32'(D_OUT), 32'(i));
      step(1'b0, 1'b1, 1'b0, 8'h00);
    end
    chk_state("drained", 5'd0, 6'b100110);

    // Streaming at COUNT=8
    step(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'(i));
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("stream start D_OUT", 32'(D_OUT), 32'h0);
    for (int k = 0; k < 100; k++) begin
      step(1'b1, 1'b1, 1'b0, 8'(8 + k));
      chk($sformatf("stream%0d D_OUT", k), 32'(D_OUT), 32'(k + 1));
      chk_state($sformatf("stream%0d", k), 5'd8, 6'b110000);
    end

    // ENQ & DEQ together at full, then CLR
    step(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 8'(i));
    chk_state("full", 5'd16, 6'b011000);
    step(1'b1, 1'b1, 1'b0, 8'hEE);
    chk_state("full enq+deq", 5'd15, 6'b111010);
    chk("full enq+deq D_OUT", 32'(D_OUT), 32'h1);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk_state("clr after ovf", 5'd0, 6'b100100);

    // CLR at COUNT=5 with ENQ asserted, then fresh ENQ of 0x3C
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h50 + i));
    chk_state("pre-clr", 5'd5, 6'b110000);
    step(1'b1, 1'b0, 1'b1, 8'h77);
    chk_state("clr midop", 5'd0, 6'b100100);
    step(1'b1, 1'b0, 1'b0, 8'h3C);
    chk_state("post-clr enq", 5'd1, 6'b100100);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("post-clr +1 EMPTY_N", 32'(EMPTY_N), 32'h0);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk_state("post-clr +2", 5'd1, 6'b110100);
    chk("post-clr +2 D_OUT", 32'(D_OUT), 32'h3C);

    // Asynchronous reset mid-cycle after setting UNF
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("pre-rst UNF", 32'(UNF), 32'h1);
    step(1'b1, 1'b0, 1'b0, 8'h99);
    @(negedge CLK);
    ENQ = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    chk_state("async rst", 5'd0, 6'b100100);
    chk("async rst D_OUT", 32'(D_OUT), 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ar_srl_fifo_lvl.md
Name: ar_srl_fifo_lvl

Overview:
- Parametrised SRL-based FIFO with a registered output stage for high Fmax.
- Next-generation replacement for the fixed single-mode SRL FIFO. Adds an occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags.
- Used on OCPI worker data paths where upstream throttling needs early warning and misuse must be latched for software.

Parameters:
- width, 128, data word width in bits.
- l2depth, 5, log2 of total capacity.
- depth, 2**l2depth, total capacity in words (SRL plus output register); derived, not overridden.
- af_thresh, depth-2, AFULL asserts when COUNT >= af_thresh; legal range 1..depth.
- ae_thresh, 1, AEMPTY asserts when COUNT <= ae_thresh; legal range 0..depth-1.

Ports:
- CLK  in  1  single clock; all logic is on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- CLR  in  1  synchronous clear, active-high; same effect as reset, and also clears the error flags.
- ENQ  in  1  enqueue request.
- D_IN  in  width  enqueue data.
- DEQ  in  1  dequeue request; consumes the word currently on D_OUT.
- FULL_N  out  1  registered; 1 = space available.
- EMPTY_N  out  1  registered; 1 = D_OUT valid.
- D_OUT  out  width  output register contents.
- COUNT  out  l2depth+1  registered occupancy, 0..depth.
- AFULL  out  1  registered almost-full flag.
- AEMPTY  out  1  registered almost-empty flag.
- OVF  out  1  sticky; set by an ENQ while FULL_N=0.
- UNF  out  1  sticky; set by a DEQ while EMPTY_N=0.

Behaviour:
- Reset (RST=1, asynchronous) or CLR=1 (sampled at the edge) forces:
  - COUNT=0, FULL_N=1, EMPTY_N=0, AFULL=0, AEMPTY=1, D_OUT=0.
  - SRL head pointer = 0, internal SRL-empty flag = 1.
  - CLR and RST also clear OVF and UNF.
  - SRL storage contents are not reset.
- Acceptance uses the registered flags:
  - enq_ok = ENQ & FULL_N.
  - deq_ok = DEQ & EMPTY_N.
- Rejected requests:
  - ENQ while FULL_N=0 is dropped (no state change) and sets OVF.
  - DEQ while EMPTY_N=0 is dropped and sets UNF.
  - OVF and UNF hold until CLR or RST.
- Storage:
  - On enq_ok, the SRL shifts and entry 0 takes D_IN.
  - The SRL head pointer tracks words held in the SRL (excludes the output register): +1 on enq only, -1 on move-out only, unchanged on both or neither.
- Output register advance (move-out) happens at an edge when the SRL is non-empty and either:
  - the output register is empty, or
  - deq_ok is true.
  - On move-out, D_OUT takes the oldest SRL word and EMPTY_N becomes 1.
  - If deq_ok occurs and the SRL is empty, EMPTY_N becomes 0 and D_OUT holds its stale value.
- Latency:
  - A word enqueued into an empty FIFO at edge N is on D_OUT with EMPTY_N=1 after edge N+2.
  - Back-to-back DEQ sustains 1 word/cycle while the SRL is non-empty.
- COUNT:
  - Increments on enq_ok only, decrements on deq_ok only, unchanged on both or neither.
  - Never wraps; the error rules above guarantee the 0..depth range.
- Flag timing:
  - FULL_N = !(next COUNT == depth).
  - AFULL = (next COUNT >= af_thresh).
  - AEMPTY = (next COUNT <= ae_thresh).
  - All three are registered from next COUNT, so they are coherent with COUNT on the same cycle.
  - EMPTY_N may lag COUNT by up to 2 cycles after an enqueue into empty; this is by design.
- Simultaneous events:
  - At full with ENQ & DEQ: only the DEQ is accepted (FULL_N was 0); COUNT becomes depth-1 and OVF is set.
  - At EMPTY_N=0 with ENQ & DEQ: only the ENQ is accepted; UNF is set.
  - Mid-level ENQ & DEQ: both are accepted and COUNT is unchanged.
- Reset or CLR mid-transfer discards all contents immediately; the ENQ/DEQ presented at the CLR edge are ignored and set no error flags.

Test Plan:
- Config width=8, l2depth=4 (depth=16), af_thresh=14, ae_thresh=1 for all scenarios.
- Reset: assert RST asynchronously mid-cycle -> outputs go immediately to FULL_N=1, EMPTY_N=0, COUNT=0, AEMPTY=1, D_OUT=0, OVF=UNF=0.
- Latency: single ENQ of 0xA5 at edge 0 -> COUNT=1 after edge 0; EMPTY_N=1 with D_OUT=0xA5 after edge 2; DEQ at edge 3 -> EMPTY_N=0, COUNT=0.
- Fill and ordering: ENQ 0x00..0x0F on consecutive cycles ->
  - AFULL rises with COUNT=14 and FULL_N falls with COUNT=16.
  - A 17th ENQ of 0xFF sets OVF and COUNT stays 16.
  - 16 DEQs return 0x00..0x0F in order, then EMPTY_N=0.
- Streaming: continuous ENQ & DEQ at COUNT=8 for 100 cycles -> COUNT constant at 8, data in order, no OVF/UNF.
- Boundaries:
  - ENQ & DEQ together at COUNT=16 -> COUNT=15, OVF=1.
  - DEQ on empty -> UNF=1, COUNT=0.
  - CLR -> OVF=UNF=0, COUNT=0.
- CLR mid-operation: CLR at COUNT=5 while ENQ=1 -> COUNT=0, EMPTY_N=0 next cycle, no error flags set; subsequent ENQ of 0x3C appears on D_OUT 2 cycles later.
